// File: rtl/nic_host_engine_if.sv
// Host-side bundle of the NIC host engine: tx source, rx sink and NIC register port.
interface nic_host_engine_if #(
    parameter int unsigned PW = 64
);
    logic          tx_valid;
    logic          tx_ready;
    logic [0:PW-1] tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [0:PW-1] rx_data;
    logic          nicEn;
    logic          nicWrEn;
    logic [0:1]    addr_nic;
    logic [0:PW-1] d_out_nic;
    logic [0:PW-1] d_in_nic;

    // Engine side
    modport master (
        input  tx_valid, tx_data, rx_ready, d_in_nic,
        output tx_ready, rx_valid, rx_data, nicEn, nicWrEn, addr_nic, d_out_nic
    );

    // Source / sink / NIC side
    modport slave (
        output tx_valid, tx_data, rx_ready, d_in_nic,
        input  tx_ready, rx_valid, rx_data, nicEn, nicWrEn, addr_nic, d_out_nic
    );
endinterface

// File: rtl/nic_host_engine.sv
// NIC host engine: buffers outgoing packets, polls NIC status, writes the
// output channel buffer and drains the input channel buffer to a sink.
module nic_host_engine #(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    nic_host_engine_if.master    bus,
    output logic [CNT_WIDTH-1:0] tx_count,
    output logic [CNT_WIDTH-1:0] rx_count
);
    localparam int unsigned PW = PACKET_WIDTH;
    localparam int unsigned AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_POLL_RX  = 3'd1;
    localparam logic [2:0] S_READ_RX  = 3'd2;
    localparam logic [2:0] S_POLL_TX  = 3'd3;
    localparam logic [2:0] S_WRITE_TX = 3'd4;

    localparam logic PRIO_RX = 1'b0;
    localparam logic PRIO_TX = 1'b1;

    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STS  = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STS = 2'b11;

    // FSM and arbitration state
    logic [2:0] state_q, state_d;
    logic       prio_q, prio_d;

    // Registered NIC port
    logic          nic_en_q, nic_en_d;
    logic          nic_wr_q, nic_wr_d;
    logic [0:1]    addr_q, addr_d;
    logic [0:PW-1] dout_q, dout_d;

    // Outgoing FIFO
    logic [0:PW-1] mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ_q, occ_d;
    logic          tx_ready_q;
    logic          push, pop, fifo_empty;

    // Receive holding register
    logic          rx_valid_q;
    logic [0:PW-1] rx_data_q;
    logic          rx_load;
    logic          status_full;

    assign push        = bus.tx_valid && tx_ready_q;
    assign fifo_empty  = (occ_q == '0);
    assign status_full = bus.d_in_nic[PW-1];

    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.nicEn     = nic_en_q;
    assign bus.nicWrEn   = nic_wr_q;
    assign bus.addr_nic  = addr_q;
    assign bus.d_out_nic = dout_q;

    // Next-state, arbitration and next NIC access
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        nic_en_d = 1'b0;
        nic_wr_d = 1'b0;
        addr_d   = A_IN_BUF;
        dout_d   = '0;
        pop      = 1'b0;
        rx_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_valid_q && (fifo_empty || prio_q == PRIO_RX)) begin
                    state_d  = S_POLL_RX;
                    nic_en_d = 1'b1;
                    addr_d   = A_IN_STS;
                end else if (!fifo_empty) begin
                    state_d  = S_POLL_TX;
                    nic_en_d = 1'b1;
                    addr_d   = A_OUT_STS;
                end
            end
            S_POLL_RX: begin
                if (status_full) begin
                    state_d  = S_READ_RX;
                    nic_en_d = 1'b1;
                    addr_d   = A_IN_BUF;
                end else begin
                    state_d = S_IDLE;
                    prio_d  = PRIO_TX;
                end
            end
            S_READ_RX: begin
                rx_load = 1'b1;
                prio_d  = PRIO_TX;
                state_d = S_IDLE;
            end
            S_POLL_TX: begin
                if (!status_full) begin
                    state_d  = S_WRITE_TX;
                    nic_en_d = 1'b1;
                    nic_wr_d = 1'b1;
                    addr_d   = A_OUT_BUF;
                    dout_d   = mem[rd_ptr];
                end else begin
                    state_d = S_IDLE;
                    prio_d  = PRIO_RX;
                end
            end
            S_WRITE_TX: begin
                pop     = 1'b1;
                prio_d  = PRIO_RX;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, priority and NIC port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            prio_q   <= PRIO_RX;
            nic_en_q <= 1'b0;
            nic_wr_q <= 1'b0;
            addr_q   <= A_IN_BUF;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            nic_en_q <= nic_en_d;
            nic_wr_q <= nic_wr_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
        end
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // FIFO pointers, occupancy and registered not-full flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ_q      <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ_q      <= occ_d;
            tx_ready_q <= (occ_d != OW'(TX_DEPTH));
        end
    end

    // FIFO storage; contents are meaningless while empty so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    // Received packet holding register, held until the sink accepts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else if (rx_load) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= bus.d_in_nic;
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Sent / received packet counters, wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (pop) begin
                tx_count <= tx_count + CNT_WIDTH'(1);
            end
            if (rx_load) begin
                rx_count <= rx_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nic_host_engine.sv
// Self-checking bench for nic_host_engine: directed scenarios plus random
// traffic against a queue-based model of the FIFO, NIC buffers and sink.
module tb_nic_host_engine;
    localparam int unsigned PW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] tx_count, rx_count;

    nic_host_engine_if #(.PW(PW)) bus ();

    nic_host_engine #(
        .PACKET_WIDTH(PW),
        .TX_DEPTH    (DEPTH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .tx_count(tx_count),
        .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    // NIC model state driven by the stimulus
    logic          in_full, out_full;
    logic [PW-1:0] in_pkt;

    // NIC register read data: status words carry the full flag in every bit
    always_comb begin
        case (bus.addr_nic)
            2'b00:   bus.d_in_nic = in_pkt;
            2'b01:   bus.d_in_nic = {PW{in_full}};
            2'b11:   bus.d_in_nic = {PW{out_full}};
            default: bus.d_in_nic = '0;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Reference model: packets pushed but not yet written, packets read but not yet consumed
    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    int  n_wr, n_rd;
    int  prev_kind;
    logic prev_full;

    // Per-cycle protocol and data checks against the model
    always @(negedge clk) begin
        int   cur_kind;
        logic cur_full;
        logic [PW-1:0] exp_pkt;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            n_wr      = 0;
            n_rd      = 0;
            prev_kind = 0;
            prev_full = 1'b0;
        end else begin
            cur_kind = 0;
            cur_full = 1'b0;
            check_eq("tx_ready", 64'(bus.tx_ready), 64'(txq.size() < DEPTH));
            check_eq("rx_valid", 64'(bus.rx_valid), 64'(rxq.size() != 0));
            check_eq("tx_count", 64'(tx_count), 64'(CW'(n_wr)));
            check_eq("rx_count", 64'(rx_count), 64'(CW'(n_rd)));
            if (bus.nicEn) begin
                case (bus.addr_nic)
                    2'b01: begin
                        check_eq("poll_in_wr", 64'(bus.nicWrEn), 64'(0));
                        check_eq("poll_in_while_held", 64'(bus.rx_valid), 64'(0));
                        cur_kind = 1;
                        cur_full = bus.d_in_nic[PW-1];
                    end
                    2'b11: begin
                        check_eq("poll_out_wr", 64'(bus.nicWrEn), 64'(0));
                        cur_kind = 2;
                        cur_full = bus.d_in_nic[PW-1];
                    end
                    2'b00: begin
                        check_eq("read_wr", 64'(bus.nicWrEn), 64'(0));
                        check_eq("read_after_full_poll", 64'(prev_kind == 1 && prev_full), 64'(1));
                        rxq.push_back(bus.d_in_nic);
                        n_rd++;
                    end
                    default: begin
                        check_eq("write_wr", 64'(bus.nicWrEn), 64'(1));
                        check_eq("write_after_free_poll", 64'(prev_kind == 2 && !prev_full), 64'(1));
                        if (txq.size() == 0) begin
                            check_eq("write_unexpected", 64'(1), 64'(0));
                        end else begin
                            exp_pkt = txq.pop_front();
                            check_eq("write_order", bus.d_out_nic, exp_pkt);
                        end
                        n_wr++;
                    end
                endcase
            end else begin
                check_eq("idle_bus", {bus.d_out_nic[0:PW-4], bus.nicWrEn, bus.addr_nic}, 64'(0));
                check_eq("idle_dout_tail", 64'(bus.d_out_nic[PW-3:PW-1]), 64'(0));
            end
            if (bus.rx_valid && bus.rx_ready && rxq.size() != 0) begin
                exp_pkt = rxq.pop_front();
                check_eq("rx_data", bus.rx_data, exp_pkt);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                txq.push_back(bus.tx_data);
            end
            prev_kind = cur_kind;
            prev_full = cur_full;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        int cnt;
        int idx;
        int last_kind, kind, viol, n_rxk, n_txk;
        logic [PW-1:0] base;

        reset        = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'h1234_5678_9ABC_DEF0;
        bus.rx_ready = 1'b0;
        in_full      = 1'b0;
        out_full     = 1'b0;
        in_pkt       = '0;

        // Reset held with a source offering data
        repeat (3) @(negedge clk);
        check_eq("rst_nicEn", 64'(bus.nicEn), 64'(0));
        check_eq("rst_tx_ready", 64'(bus.tx_ready), 64'(1));
        check_eq("rst_rx_valid", 64'(bus.rx_valid), 64'(0));
        check_eq("rst_counts", 64'({tx_count, rx_count}), 64'(0));
        cyc();
        bus.tx_valid = 1'b0;
        reset        = 1'b1;

        // RX drain with a stalled sink
        in_full = 1'b1;
        in_pkt  = 64'h0000_0000_DEAD_BEEF;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_valid) begin got = 1; break; end
        end
        check_eq("t4_rx_arrives", 64'(got), 64'(1));
        check_eq("t4_rx_data", bus.rx_data, 64'h0000_0000_DEAD_BEEF);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.nicEn && bus.addr_nic == 2'b01) cnt++;
        end
        check_eq("t4_no_polls", 64'(cnt), 64'(0));
        check_eq("t4_rx_held", bus.rx_data, 64'h0000_0000_DEAD_BEEF);
        check_eq("t4_rx_count", 64'(rx_count), 64'(1));

        // Single TX with exact access timing
        in_full = 1'b0;
        cyc();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'hA5A5_0000_0000_0001;
        cyc();
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_idle", 64'(bus.nicEn), 64'(0));
        @(negedge clk);
        check_eq("t2_poll", 64'({bus.nicEn, bus.nicWrEn, bus.addr_nic}), 64'(4'b1011));
        @(negedge clk);
        check_eq("t2_write", 64'({bus.nicEn, bus.nicWrEn, bus.addr_nic}), 64'(4'b1110));
        check_eq("t2_data", bus.d_out_nic, 64'hA5A5_0000_0000_0001);
        @(negedge clk);
        check_eq("t2_tx_count", 64'(tx_count), 64'(1));

        // Backpressure: NIC output buffer full while 5 packets are offered
        base     = 64'hB000_0000_0000_0000;
        out_full = 1'b1;
        cyc();
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = base + 64'(k);
            @(negedge clk);
            if (bus.tx_ready) cnt++;
            cyc();
        end
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_accepted", 64'(cnt), 64'(4));
        check_eq("t3_full", 64'(bus.tx_ready), 64'(0));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.nicEn && bus.nicWrEn) cnt++;
        end
        check_eq("t3_no_write_while_full", 64'(cnt), 64'(0));
        cyc();
        out_full = 1'b0;
        idx = 0;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            @(negedge clk);
            if (bus.nicEn && bus.nicWrEn) begin
                check_eq("t3_order", bus.d_out_nic, base + 64'(idx));
                idx++;
            end
        end
        check_eq("t3_writes", 64'(idx), 64'(4));
        @(negedge clk);
        check_eq("t3_tx_count", 64'(tx_count), 64'(5));

        // Arbitration: both sides always ready, accesses must alternate
        cyc();
        bus.rx_ready = 1'b1;
        in_full      = 1'b1;
        last_kind = 0; viol = 0; n_rxk = 0; n_txk = 0;
        for (int i = 0; i < 90; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = {$urandom, $urandom};
            in_pkt       = {$urandom, $urandom};
            @(negedge clk);
            kind = 0;
            if (bus.nicEn && bus.addr_nic == 2'b00) begin kind = 1; n_rxk++; end
            if (bus.nicEn && bus.addr_nic == 2'b10) begin kind = 2; n_txk++; end
            if (kind != 0) begin
                if (kind == last_kind) viol++;
                last_kind = kind;
            end
            cyc();
        end
        check_eq("t5_alternate", 64'(viol), 64'(0));
        check_eq("t5_rx_served", 64'(n_rxk >= 10), 64'(1));
        check_eq("t5_tx_served", 64'(n_txk >= 10), 64'(1));

        // Drain, then reset in the middle of a NIC write
        bus.tx_valid = 1'b0;
        in_full      = 1'b0;
        out_full     = 1'b0;
        repeat (40) cyc();
        out_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 64'hC000_0000_0000_0000 + 64'(k);
            cyc();
        end
        bus.tx_valid = 1'b0;
        out_full     = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.nicEn && bus.nicWrEn) begin got = 1; break; end
        end
        check_eq("t6_write_seen", 64'(got), 64'(1));
        #2 reset = 1'b0;
        #1;
        check_eq("t6_bus_clear", 64'({bus.nicEn, bus.nicWrEn, bus.addr_nic}), 64'(0));
        check_eq("t6_dout_clear", bus.d_out_nic, 64'(0));
        check_eq("t6_tx_ready", 64'(bus.tx_ready), 64'(1));
        check_eq("t6_counts", 64'({tx_count, rx_count}), 64'(0));
        repeat (2) cyc();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.nicEn && bus.nicWrEn) cnt++;
        end
        check_eq("t6_no_write_after", 64'(cnt), 64'(0));

        // Random traffic against the model
        cyc();
        for (int i = 0; i < 3000; i++) begin
            bus.tx_valid = ($urandom_range(0, 1) == 1);
            bus.tx_data  = {$urandom, $urandom};
            bus.rx_ready = ($urandom_range(0, 9) < 6);
            in_full      = ($urandom_range(0, 1) == 1);
            out_full     = ($urandom_range(0, 2) == 0);
            in_pkt       = {$urandom, $urandom};
            cyc();
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
